// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding, legal oversampling ratios, parity types.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } par_typ_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Anything other than 16 or 32 runs at the slowest-supported ratio of 8.
  function automatic int unsigned legal_prescale(input int unsigned p);
    return ((p == PRESCALE_16) || (p == PRESCALE_32)) ? p : PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side UART bundle: serial line and frame config in, byte and status strobes out.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timing for the receiver: counts oversampling edges and majority-votes three mid-bit samples.
// bit_done pulses on the last edge of each bit; sampled_bit is valid from edge P/2+2 onward.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic                  start,
  input  logic                  active,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic                  sampled_bit
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  bit_q, bit_d;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;

  assign half        = prescale >> 1;
  assign last        = prescale - PRESCALE_W'(1);
  assign bit_done    = active && (edge_cnt_q == last);
  assign sampled_bit = bit_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    bit_d      = bit_q;
    // The start-detect cycle is edge 0, so the count resumes at 1.
    if (start) begin
      edge_cnt_d = PRESCALE_W'(1);
    end else if (active) begin
      edge_cnt_d = bit_done ? '0 : edge_cnt_q + PRESCALE_W'(1);
    end else begin
      edge_cnt_d = '0;
    end
    if (active) begin
      if (edge_cnt_q == half - PRESCALE_W'(1)) s0_d = rx_in;
      if (edge_cnt_q == half)                  s1_d = rx_in;
      if (edge_cnt_q == half + PRESCALE_W'(1)) bit_d = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      bit_q      <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      bit_q      <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start detect, LSB-first deserialise, optional parity, stop check.
// Strobes land P*(10+PAR_EN) cycles after start detect; no backpressure, one byte per frame.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input logic            CLK,
  input logic            RST,
  uart_rx_frame_if.slave rx_if
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_fail_q, par_fail_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  start;
  logic                  bit_done;
  logic                  sampled_bit;

  assign start = (state_q == IDLE) && !rx_if.RX_IN;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (rx_if.RX_IN),
    .start       (start),
    .active      (state_q != IDLE),
    .prescale    (prescale_q),
    .bit_done    (bit_done),
    .sampled_bit (sampled_bit)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    par_fail_d   = par_fail_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    prescale_d   = prescale_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START;
          par_fail_d = 1'b0;
          par_en_d   = rx_if.PAR_EN;
          par_typ_d  = rx_if.PAR_TYP;
          prescale_d = PRESCALE_W'(legal_prescale(32'(rx_if.Prescale)));
        end
      end
      START: begin
        if (bit_done) begin
          // A start bit that votes high was line noise.
          if (sampled_bit) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_d   = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_fail_d = ((^shreg_q) ^ par_typ_q) != sampled_bit;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d   = IDLE;
          par_err_d = par_fail_q;
          stp_err_d = !sampled_bit;
          if (sampled_bit && !par_fail_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shreg_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      p_data_q     <= '0;
      par_fail_q   <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      prescale_q   <= PRESCALE_W'(PRESCALE_8);
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      par_fail_q   <= par_fail_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      prescale_q   <= prescale_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign rx_if.P_DATA     = p_data_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.par_err    = par_err_q;
  assign rx_if.stp_err    = stp_err_q;

endmodule
